// File: rtl/sys_io_poll_scheduler.sv
// Poll scheduler for the external controller chip: raises poll requests at a fixed rate,
// frames START + 8 button bytes + joy_y + joy_x, and commits complete snapshots atomically.
module sys_io_poll_scheduler #(
  parameter int unsigned POLL_PERIOD    = 1_600_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [7:0]  START_CHAR     = 8'hFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        poll_req_out,
  output logic [23:0] controller_out,
  output logic        controller_valid_out,
  output logic        link_up_out,
  output logic        busy_out,
  output logic [15:0] frame_count_out,
  output logic [15:0] error_count_out
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_RX_BTN, S_RX_JOY_Y, S_RX_JOY_X
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]  retry_q, retry_d;
  logic        retry_pend_q, retry_pend_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  btn_q, btn_d;
  logic [7:0]  joy_y_q, joy_y_d;
  logic [23:0] ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic        link_q, link_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] err_q, err_d;
  logic        tick, err, taken;

  // The poll timer free-runs while enabled; ticks seen outside plain IDLE are simply lost.
  always_comb begin
    tick   = enable_in && (poll_q == PW'(POLL_PERIOD - 1));
    poll_d = poll_q + 1'b1;
    if (!enable_in || tick) poll_d = '0;
  end

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
    bcnt_d       = bcnt_q;
    btn_d        = btn_q;
    joy_y_d      = joy_y_q;
    ctrl_d       = ctrl_q;
    valid_d      = 1'b0;
    link_d       = link_q;
    frame_d      = frame_q;
    err_d        = err_q;
    err          = 1'b0;
    taken        = 1'b0;

    if (!enable_in) begin
      state_d      = S_IDLE;
      retry_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (retry_pend_q) begin
            state_d      = S_WAIT_START;
            to_d         = '0;
            retry_pend_d = 1'b0;
          end else if (tick) begin
            state_d = S_WAIT_START;
            to_d    = '0;
            retry_d = '0;
          end
        end
        S_WAIT_START: begin
          if (byte_valid_in && byte_in == START_CHAR) begin
            taken   = 1'b1;
            state_d = S_RX_BTN;
            to_d    = '0;
            bcnt_d  = '0;
            btn_d   = '0;
          end
        end
        S_RX_BTN: begin
          if (byte_valid_in) begin
            taken = 1'b1;
            if (byte_in[7:1] != 7'd0) begin
              err = 1'b1;
            end else begin
              btn_d  = {btn_q[6:0], byte_in[0]};
              bcnt_d = bcnt_q + 3'd1;
              to_d   = '0;
              if (bcnt_q == 3'd7) state_d = S_RX_JOY_Y;
            end
          end
        end
        S_RX_JOY_Y: begin
          if (byte_valid_in) begin
            taken   = 1'b1;
            joy_y_d = byte_in;
            to_d    = '0;
            state_d = S_RX_JOY_X;
          end
        end
        S_RX_JOY_X: begin
          if (byte_valid_in) begin
            taken   = 1'b1;
            state_d = S_IDLE;
            ctrl_d  = {byte_in, joy_y_q, btn_q};
            valid_d = 1'b1;
            frame_d = frame_q + 16'd1;
            link_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A byte arriving in the expiry cycle wins over the timeout.
      if (state_q != S_IDLE && !taken) begin
        if (to_q == TW'(TIMEOUT_CYCLES - 1)) err = 1'b1;
        else to_d = to_q + 1'b1;
      end

      if (err) begin
        state_d = S_IDLE;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (retry_q < 4'(MAX_RETRIES)) begin
          retry_d      = retry_q + 4'd1;
          retry_pend_d = 1'b1;
        end else begin
          link_d       = 1'b0;
          retry_pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      poll_q       <= '0;
      to_q         <= '0;
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
      bcnt_q       <= '0;
      btn_q        <= '0;
      joy_y_q      <= '0;
      ctrl_q       <= {8'h80, 8'h80, 8'h00};
      valid_q      <= 1'b0;
      link_q       <= 1'b0;
      frame_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      poll_q       <= poll_d;
      to_q         <= to_d;
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
      bcnt_q       <= bcnt_d;
      btn_q        <= btn_d;
      joy_y_q      <= joy_y_d;
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      link_q       <= link_d;
      frame_q      <= frame_d;
      err_q        <= err_d;
    end
  end

  assign poll_req_out         = (state_q == S_WAIT_START);
  assign busy_out             = (state_q != S_IDLE);
  assign controller_out       = ctrl_q;
  assign controller_valid_out = valid_q;
  assign link_up_out          = link_q;
  assign frame_count_out      = frame_q;
  assign error_count_out      = err_q;

endmodule
